// File: rtl/accum_drain_serializer_pkg.sv
// Shared constants and types for the accumulator drain / serializer slice.
package accum_drain_serializer_pkg;

    localparam int unsigned GRID    = 12;
    localparam int unsigned ACC_W   = 20;
    localparam int unsigned OUT_W   = 16;
    localparam int unsigned SHIFT_W = 4;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] STREAM = 2'd1;
    localparam logic [1:0] FINISH = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE   = IDLE,
        S_STREAM = STREAM,
        S_FINISH = FINISH
    } state_e;

    // Post-quantisation settings shared by the drain and writeback paths.
    typedef struct packed {
        logic               relu_en;
        logic [SHIFT_W-1:0] shift;
    } quant_cfg_t;

endpackage

// File: rtl/accum_drain_serializer_if.sv
// Valid/ready output word stream from the drain toward output writeback.
interface accum_drain_serializer_if #(
    parameter int unsigned DATA_W = accum_drain_serializer_pkg::OUT_W
);
    logic [DATA_W-1:0] o_data;
    logic              o_valid;
    logic              o_ready;
    logic              o_last;

    modport master (output o_data, output o_valid, output o_last, input o_ready);
    modport slave  (input o_data, input o_valid, input o_last, output o_ready);
endinterface

// File: rtl/accum_post_quant.sv
// Combinational ReLU, arithmetic right shift and saturation from IN_W to RES_W.
module accum_post_quant
    import accum_drain_serializer_pkg::*;
#(
    parameter int unsigned IN_W  = ACC_W,
    parameter int unsigned RES_W = OUT_W
) (
    input  logic signed [IN_W-1:0]  value,
    input  quant_cfg_t              cfg,
    output logic signed [RES_W-1:0] result_c
);

    localparam logic signed [IN_W-1:0] SAT_MAX = IN_W'((64'sd1 <<< (RES_W - 1)) - 64'sd1);
    localparam logic signed [IN_W-1:0] SAT_MIN = ~SAT_MAX;

    logic signed [IN_W-1:0] relu_c;
    logic signed [IN_W-1:0] shifted_c;

    always_comb begin
        relu_c    = (cfg.relu_en && value[IN_W-1]) ? '0 : value;
        shifted_c = relu_c >>> cfg.shift;
        if (shifted_c > SAT_MAX) begin
            result_c = SAT_MAX[RES_W-1:0];
        end else if (shifted_c < SAT_MIN) begin
            result_c = SAT_MIN[RES_W-1:0];
        end else begin
            result_c = shifted_c[RES_W-1:0];
        end
    end

endmodule

// File: rtl/accum_drain_serializer.sv
// Snapshots the GRID x GRID accumulator bus and streams the valid limit x limit
// window row-major as quantised words over a valid/ready interface.
module accum_drain_serializer
    import accum_drain_serializer_pkg::state_e, accum_drain_serializer_pkg::quant_cfg_t,
           accum_drain_serializer_pkg::S_IDLE, accum_drain_serializer_pkg::S_STREAM,
           accum_drain_serializer_pkg::S_FINISH;
#(
    parameter int unsigned GRID  = accum_drain_serializer_pkg::GRID,
    parameter int unsigned ACC_W = accum_drain_serializer_pkg::ACC_W,
    parameter int unsigned OUT_W = accum_drain_serializer_pkg::OUT_W
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [ACC_W*GRID*GRID-1:0]  accum_in,
    input  logic [4:0]                  act_size,
    input  logic [2:0]                  filter_size,
    input  logic                        relu_en,
    input  logic [3:0]                  shift,
    output logic                        busy,
    output logic                        drain_done,
    accum_drain_serializer_if.master    out_if
);

    localparam int unsigned CNT_W = $clog2(GRID + 1);
    localparam int unsigned IDX_W = $clog2(GRID * GRID);

    state_e                     state;
    logic [ACC_W*GRID*GRID-1:0] snap;
    quant_cfg_t                 cfg;
    logic [CNT_W-1:0]           limit;
    logic [CNT_W-1:0]           row;
    logic [CNT_W-1:0]           col;

    logic signed [5:0]          lim_raw_c;
    logic [CNT_W-1:0]           limit_c;
    logic [CNT_W-1:0]           lim_m1_c;
    logic [IDX_W-1:0]           idx_c;
    logic signed [ACC_W-1:0]    entry_c;
    logic signed [OUT_W-1:0]    quant_c;

    // Window side in 6-bit signed arithmetic; non-positive means empty, clamp to GRID.
    always_comb begin
        lim_raw_c = $signed({1'b0, act_size}) - $signed({3'b000, filter_size}) + 6'sd1;
        limit_c   = '0;
        if (lim_raw_c > $signed(6'(GRID))) begin
            limit_c = CNT_W'(GRID);
        end else if (lim_raw_c > 6'sd0) begin
            limit_c = CNT_W'(lim_raw_c);
        end
    end

    assign lim_m1_c = CNT_W'(limit - CNT_W'(1));
    assign idx_c    = IDX_W'(row) * IDX_W'(GRID) + IDX_W'(col);
    assign entry_c  = $signed(snap[idx_c*ACC_W +: ACC_W]);

    accum_post_quant #(
        .IN_W  (ACC_W),
        .RES_W (OUT_W)
    ) u_quant (
        .value    (entry_c),
        .cfg      (cfg),
        .result_c (quant_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            snap           <= '0;
            cfg            <= '0;
            limit          <= '0;
            row            <= '0;
            col            <= '0;
            busy           <= 1'b0;
            drain_done     <= 1'b0;
            out_if.o_data  <= '0;
            out_if.o_valid <= 1'b0;
            out_if.o_last  <= 1'b0;
        end else begin
            drain_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        snap        <= accum_in;
                        cfg.relu_en <= relu_en;
                        cfg.shift   <= shift;
                        limit       <= limit_c;
                        row         <= '0;
                        col         <= '0;
                        busy        <= 1'b1;
                        state       <= (limit_c == '0) ? S_FINISH : S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (!out_if.o_valid || out_if.o_ready) begin
                        // A registered o_last means every word has been loaded already.
                        if (out_if.o_valid && out_if.o_last) begin
                            out_if.o_valid <= 1'b0;
                            out_if.o_last  <= 1'b0;
                            state          <= S_FINISH;
                        end else begin
                            out_if.o_data  <= quant_c;
                            out_if.o_valid <= 1'b1;
                            out_if.o_last  <= (row == lim_m1_c) && (col == lim_m1_c);
                            if (col == lim_m1_c) begin
                                col <= '0;
                                row <= CNT_W'(row + CNT_W'(1));
                            end else begin
                                col <= CNT_W'(col + CNT_W'(1));
                            end
                        end
                    end
                end
                S_FINISH: begin
                    drain_done <= 1'b1;
                    busy       <= 1'b0;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/accum_drain_serializer.md
Name: accum_drain_serializer

Overview:
- Read side of the accumulator array produced by the buffer/MCC/router-accumulate datapath.
- On a start pulse (driven from the MCC done), it snapshots the flattened GRID x GRID accumulator bus.
- It then walks only the valid output window, limit x limit with limit = act_size - filter_size + 1, in row-major order.
- Each element gets optional ReLU, an arithmetic right shift and saturation, and leaves as one OUT_W-bit word per valid/ready beat toward the output writeback.

Parameters:
- GRID, 12, side of the accumulator array; the input bus holds GRID*GRID entries.
- ACC_W, 20, signed two's-complement width of each accumulator entry.
- OUT_W, 16, signed width of each output word.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; begin a drain of accum_in.
- accum_in  input  ACC_W*GRID*GRID  flattened accumulators; entry k = bits [k*ACC_W +: ACC_W], with k = row*GRID + col.
- act_size  input  5  activation side length; sampled on start.
- filter_size  input  3  filter side length; sampled on start.
- relu_en  input  1  clamp negatives to 0; sampled on start.
- shift  input  4  arithmetic right-shift amount; sampled on start.
- o_data  output  OUT_W  output word.
- o_valid  output  1  o_data is valid.
- o_ready  input  1  downstream accepts the word.
- o_last  output  1  high with the final word of the window.
- busy  output  1  drain in progress (state != IDLE).
- drain_done  output  1  one-cycle pulse when the drain finishes.

Behaviour:
- Reset values: all outputs 0, state IDLE, row/col counters 0, snapshot register 0.
- Limit: computed in 6-bit signed arithmetic as act_size - filter_size + 1, latched on start.
  - limit <= 0 gives an empty window.
  - limit > GRID is clamped to GRID.
- FSM has three states: IDLE, STREAM, FINISH.
- IDLE:
  - start=1 at edge k captures accum_in, relu_en, shift and the limit.
  - Sets row=col=0.
  - Goes to STREAM, or to FINISH if the window is empty.
- STREAM: the output register loads when o_valid==0 or o_ready==1.
  - Loaded value: o_data = sat(shr(relu(entry[row*GRID+col]))), o_valid=1, o_last=1 iff row==limit-1 and col==limit-1.
  - Then col increments; at limit-1 it wraps to 0 and row increments.
  - First o_valid is at edge k+1 after start sampled at edge k.
  - With o_ready held high, one word per cycle.
- Handshake rules:
  - A transfer occurs on a cycle with o_valid && o_ready.
  - o_data and o_last stay stable while o_valid && !o_ready.
  - o_valid never drops without a transfer.
- End of window: when the o_last word transfers and nothing is pending, o_valid clears and the FSM goes to FINISH.
- FINISH: drain_done=1 for exactly one cycle, then IDLE.
  - Empty window: drain_done arrives at edge k+1 and o_valid never rises.
- Arithmetic, in order:
  1. relu: if relu_en and the value is negative, use 0.
  2. shr: arithmetic right shift by shift.
  3. sat: clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- start while busy is ignored; the snapshot is not disturbed.
- accum_in may change freely after the start cycle.
- Reset asserted mid-drain: immediate return to reset values and no drain_done pulse.
- Total words emitted = limit*limit, max 144.

Decomposition:
- Shared package holds:
  - GRID, ACC_W and OUT_W defaults.
  - The state encoding localparams (IDLE=2'd0, STREAM=2'd1, FINISH=2'd2).
- One natural sub-module: accum_post_quant, combinational ReLU, shift and saturate from ACC_W to OUT_W. It is reused later by the writeback path.

Test Plan:
- act_size=14, filter_size=3 (limit 12), entry k = k, relu_en=0, shift=0, o_ready=1 -> 144 words 0..143 on consecutive cycles; first o_valid 1 cycle after start; o_last on word 143; drain_done 1 cycle later.
- act_size=5, filter_size=3 (limit 3), entry k = k -> words 0,1,2,12,13,14,24,25,26; o_last on 26.
- Entries -5, 40000, 1000; relu_en=1; shift=1; limit 2 -> output 0, 20000, 500; with relu_en=0, shift=0: -5, 32767 (saturated), 1000.
- o_ready toggled 1,0,0,1,... -> o_data and o_last held during stalls; no word lost or duplicated; second start pulse during the drain ignored.
- act_size=2, filter_size=3 -> no o_valid; drain_done at start+1; busy high for exactly 1 cycle.
- Reset asserted after 5 of 9 words -> outputs 0 immediately, no drain_done; a new start afterwards drains the full window from word 0.
